noc_input_queue: RTL and testbench
==================================

// Module: noc_input_queue
// PURPOSE
//  Per-agent ingress buffering in front of the round-robin port arbiter.
//  Holds flits from NUM_AGENTS sources in independent FIFOs and raises request[i] while queue i is non-empty.
//  Consumes the arbiter's one-hot grant to pop the winning head flit into a registered output slot toward the switch.
// PARAMETERS
//  NUM_AGENTS  4   number of sources; matches arbiter num_Agents (power of 2, >=2)
//  DATA_W      32  flit payload width
//  DEPTH       4   entries per agent FIFO (power of 2, >=2)
// PORTS
//  clk        in   1                 clock; all state updates on posedge
//  rst_n      in   1                 asynchronous active-low reset
//  in_valid   in   NUM_AGENTS        per-agent push strobe
//  in_data    in   NUM_AGENTS*DATA_W per-agent flit, agent i at [i*DATA_W +: DATA_W]
//  in_ready   out  NUM_AGENTS        per-agent space available (= !full[i])
//  request    out  NUM_AGENTS        to arbiter; request[i] = !empty[i] & load_en
//  grant      in   NUM_AGENTS        from arbiter; combinational one-hot or zero
//  out_valid  out  1                 output slot holds a flit
//  out_data   out  DATA_W            flit in output slot
//  out_src    out  $clog2(NUM_AGENTS) agent index the flit came from
//  out_ready  in   1                 downstream accepts flit this cycle
//  err_grant  out  1                 sticky: illegal grant seen
// BEHAVIOUR
//  Reset (async, rst_n=0): all FIFOs empty, pointers/counts 0; out_valid=0, out_data=0, out_src=0,
//   err_grant=0; in_ready = all ones one cycle-independent (combinational !full); request=0.
//   Reset mid-operation discards all stored flits and the output slot contents.
//  Push: in_valid[i] & in_ready[i] writes in_data slice into FIFO i; in_valid while !in_ready is dropped.
//  No empty-FIFO bypass: pushed flit first appears on request[i] the following cycle.
//  load_en = !out_valid | out_ready (output slot free or draining this cycle).
//  request gated by load_en so the arbiter sees no requests while the output stalls.
//  Pop: when load_en & grant[i] & !empty[i]: FIFO i head -> out_data, out_src=i, out_valid=1
//   at next posedge; FIFO i read pointer advances. Latency push->out_valid min 2 cycles.
//  load_en & no legal grant: out_valid <= 0 if out_ready, else hold.
//  !load_en (out_valid & !out_ready): out_valid/out_data/out_src held stable (valid/ready rule).
//  Full + simultaneous push/pop on same FIFO: in_ready already 0, push not accepted; pop proceeds.
//  Simultaneous push on FIFO i and pop of FIFO i (not full): both happen, count unchanged.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits, 0..DEPTH.
//  Illegal grant: more than one bit set, or grant[i] with empty[i], or grant!=0 with !load_en
//   -> err_grant set (sticky until reset); no pop occurs and output behaves as no-grant case.
//  Arbiter fairness/priority is owned upstream logic; this block never reorders within one agent.
// STRUCTURE
//  noc_pkg: flit_t (logic [DATA_W-1:0]) typedef, NOC_NUM_AGENTS / NOC_FLIT_W / NOC_Q_DEPTH constants,
//   agent index typedef; shared with the arbiter and switch.
//  Sub-module noc_flit_fifo (single-clock, DEPTH x DATA_W, push/pop/full/empty/count),
//   instantiated NUM_AGENTS times via generate; top holds grant check, one-hot mux, output register.
// TESTING
//  1 Reset: drive traffic, assert rst_n=0 mid-burst -> out_valid=0, request=0, in_ready=4'b1111 immediately.
//  2 Single flit: push 0xA5A5_0001 on agent 2, grant=4'b0100 when request=4'b0100, out_ready=1
//    -> out_valid=1, out_data=0xA5A5_0001, out_src=2 two cycles after push; request returns to 0.
//  3 Full: 4 pushes on agent 0 with no grant -> in_ready[0]=0; 5th push dropped; drain yields
//    exactly the 4 flits in order.
//  4 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_src stable, request=0,
//    no FIFO count changes; out_ready=1 -> next granted flit loads same edge.
//  5 Round-robin drive: all 4 agents hold 2 flits, grant rotates 0,1,2,3,0,1,2,3 -> out_src follows
//    that sequence, per-agent data order preserved, 8 flits out in 8 cycles with out_ready=1.
//  6 Illegal grant: grant=4'b0011 or grant to empty agent -> err_grant=1 next cycle, no pop, sticky.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the ingress queue, the arbiter and the switch.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

  localparam int NOC_NUM_AGENTS = 4;   // sources feeding one switch port
  localparam int NOC_FLIT_W     = 32;  // flit payload width
  localparam int NOC_Q_DEPTH    = 4;   // entries per ingress FIFO

  typedef logic [NOC_FLIT_W-1:0]              flit_t;
  typedef logic [$clog2(NOC_NUM_AGENTS)-1:0]  agent_idx_t;

endpackage

// File: rtl/noc_flit_fifo.sv
// Single-clock flit FIFO, DEPTH x DATA_W, head visible combinationally on pop_data.
// Latency: a pushed entry is visible at the head (and in empty/count) the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; push+pop in one cycle keeps count.
// Ports: clk, rst_n | push, push_data | pop, pop_data (head) | full, empty, count (0..DEPTH).
module noc_flit_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/noc_input_queue.sv
// Per-agent ingress FIFOs feeding a registered output slot; requests go to an external arbiter.
// Latency: push -> request next cycle; grant -> out_valid next edge (push->out_valid min 2 cycles).
// Backpressure: in_ready = !full per agent; requests masked while output slot stalls (out_valid & !out_ready).
// Ports: clk, rst_n | in_valid/in_data/in_ready per agent | request/grant to/from arbiter |
//        out_valid/out_data/out_src/out_ready toward switch | err_grant sticky illegal-grant flag.
module noc_input_queue
  import noc_pkg::*;
#(
  parameter int NUM_AGENTS = NOC_NUM_AGENTS,
  parameter int DATA_W     = NOC_FLIT_W,
  parameter int DEPTH      = NOC_Q_DEPTH,
  localparam int SRC_W     = $clog2(NUM_AGENTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_AGENTS-1:0]        in_valid,
  input  logic [NUM_AGENTS*DATA_W-1:0] in_data,
  output logic [NUM_AGENTS-1:0]        in_ready,
  output logic [NUM_AGENTS-1:0]        request,
  input  logic [NUM_AGENTS-1:0]        grant,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [SRC_W-1:0]             out_src,
  input  logic                         out_ready,
  output logic                         err_grant
);

  logic [NUM_AGENTS-1:0] fifo_full;
  logic [NUM_AGENTS-1:0] fifo_empty;
  logic [NUM_AGENTS-1:0] fifo_push;
  logic [NUM_AGENTS-1:0] fifo_pop;
  logic [DATA_W-1:0]     head_dat [NUM_AGENTS];
  logic [$clog2(DEPTH):0] fifo_cnt [NUM_AGENTS];

  logic              load_en;
  logic              grant_to_idle;
  logic              grant_legal;
  logic              grant_bad;
  logic [DATA_W-1:0] sel_dat;
  logic [SRC_W-1:0]  sel_src;

  for (genvar g = 0; g < NUM_AGENTS; g++) begin : g_q
    noc_flit_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (fifo_pop[g]),
      .pop_data  (head_dat[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g]),
      .count     (fifo_cnt[g])
    );
  end

  // Slot can accept a new flit when empty or being drained this cycle.
  assign load_en   = ~out_valid | out_ready;
  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & ~fifo_full;
  assign request   = ~fifo_empty & {NUM_AGENTS{load_en}};

  always_comb begin
    grant_to_idle = 1'b0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (grant[i] && fifo_cnt[i] == '0) grant_to_idle = 1'b1;
    end
  end

  // Anything other than a single grant to a non-empty queue while the slot can load is
  // flagged and ignored, so a misbehaving arbiter can never pop a flit into a stalled slot.
  assign grant_legal = (grant != '0) & $onehot0(grant) & ~grant_to_idle & load_en;
  assign grant_bad   = (grant != '0) & ~grant_legal;
  assign fifo_pop    = grant & {NUM_AGENTS{grant_legal}};

  // AND-OR mux; only consumed when the grant is legal, i.e. exactly one-hot.
  always_comb begin
    sel_dat = '0;
    sel_src = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (grant[i]) begin
        sel_dat = sel_dat | head_dat[i];
        sel_src = sel_src | SRC_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err_grant <= 1'b0;
    end else begin
      if (grant_bad) err_grant <= 1'b1;
      if (grant_legal) begin
        out_valid <= 1'b1;
        out_data  <= sel_dat;
        out_src   <= sel_src;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_input_queue.sv
// Randomized + directed bench for noc_input_queue against a queue-based reference model.
// Latency: n/a.
// Backpressure: out_ready randomly deasserted to exercise output stalls.
module tb_noc_input_queue;

  localparam int NA  = 4;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int SW  = 2;

  typedef logic [DW-1:0] word_q_t [$];

  logic              clk;
  logic              rst_n;
  logic [NA-1:0]     in_valid;
  logic [NA*DW-1:0]  in_data;
  logic [NA-1:0]     in_ready;
  logic [NA-1:0]     request;
  logic [NA-1:0]     grant;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_src;
  logic              out_ready;
  logic              err_grant;

  // stimulus for the next cycle
  logic [NA-1:0] d_vld;
  logic [NA-1:0] d_gnt;
  logic [DW-1:0] d_dat [NA];
  logic          d_ordy;

  // reference model state
  word_q_t       mq [NA];
  logic          m_ov;
  logic [DW-1:0] m_od;
  logic [SW-1:0] m_os;
  logic          m_err;
  int            rr;

  int n_checks;
  int n_fail;

  noc_input_queue #(
    .NUM_AGENTS (NA),
    .DATA_W     (DW),
    .DEPTH      (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .request   (request),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .err_grant (err_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NA; i++) mq[i].delete();
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = '0;
    m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    d_vld = '0;
    d_gnt = '0;
    d_ordy = 1'b1;
    for (int i = 0; i < NA; i++) d_dat[i] = '0;
  endtask

  // Apply d_* at the negedge, compare DUT against the model, then advance the model
  // across the following posedge.
  task automatic step();
    logic [NA-1:0] exp_rdy;
    logic [NA-1:0] exp_req;
    logic          load;
    logic          legal;
    int            gi;
    @(negedge clk);
    in_valid  = d_vld;
    grant     = d_gnt;
    out_ready = d_ordy;
    for (int i = 0; i < NA; i++) in_data[i*DW +: DW] = d_dat[i];
    #1;
    load = !m_ov || d_ordy;
    for (int i = 0; i < NA; i++) begin
      exp_rdy[i] = mq[i].size() < DEP;
      exp_req[i] = (mq[i].size() != 0) && load;
    end
    check_eq("in_ready",  64'(in_ready),  64'(exp_rdy));
    check_eq("request",   64'(request),   64'(exp_req));
    check_eq("out_valid", 64'(out_valid), 64'(m_ov));
    check_eq("out_data",  64'(out_data),  64'(m_od));
    check_eq("out_src",   64'(out_src),   64'(m_os));
    check_eq("err_grant", 64'(err_grant), 64'(m_err));
    gi = 0;
    for (int i = 0; i < NA; i++) if (d_gnt[i]) gi = i;
    legal = ($countones(d_gnt) == 1) && (mq[gi].size() != 0) && load;
    if (legal) begin
      m_od = mq[gi].pop_front();
      m_os = SW'(gi);
      m_ov = 1'b1;
    end else if (d_ordy) begin
      m_ov = 1'b0;
    end
    if (d_gnt != '0 && !legal) m_err = 1'b1;
    for (int i = 0; i < NA; i++) if (d_vld[i] && exp_rdy[i]) mq[i].push_back(d_dat[i]);
    @(posedge clk);
  endtask

  task automatic rr_pick(input logic load, output logic [NA-1:0] g);
    int idx;
    g = '0;
    if (load) begin
      for (int k = 1; k <= NA; k++) begin
        idx = (rr + k) % NA;
        if (mq[idx].size() != 0) begin
          g[idx] = 1'b1;
          rr = idx;
          break;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_request",   64'(request),   64'd0);
    check_eq("rst_in_ready",  64'(in_ready),  64'hF);
    check_eq("rst_out_data",  64'(out_data),  64'd0);
    check_eq("rst_out_src",   64'(out_src),   64'd0);
    check_eq("rst_err_grant", 64'(err_grant), 64'd0);
    model_clear();
    idle_inputs();
    in_valid = '0;
    grant    = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_cycles(input int n, input int rst_odds);
    for (int c = 0; c < n; c++) begin
      if (rst_odds != 0 && $urandom_range(0, rst_odds - 1) == 0) do_reset();
      d_ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NA; i++) begin
        d_vld[i] = 1'($urandom_range(0, 1));
        d_dat[i] = $urandom;
      end
      if ($urandom_range(0, 99) == 0)      d_gnt = NA'($urandom);
      else if ($urandom_range(0, 4) == 0)  d_gnt = '0;
      else                                 rr_pick(!m_ov || d_ordy, d_gnt);
      step();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rr        = NA - 1;
    rst_n     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    grant     = '0;
    out_ready = 1'b1;
    idle_inputs();
    model_clear();

    // Reset, then reset again in the middle of live traffic.
    do_reset();
    random_cycles(20, 0);
    do_reset();

    // Single flit on agent 2.
    idle_inputs();
    d_vld = 4'b0100; d_dat[2] = 32'hA5A5_0001;
    step();
    d_vld = '0; d_gnt = 4'b0100;
    step();
    #1;
    check_eq("single_data", 64'(out_data), 64'hA5A5_0001);
    check_eq("single_src",  64'(out_src),  64'd2);
    d_gnt = '0;
    step();
    step();

    // Fill agent 0 (5th push dropped), then drain in order.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      d_vld = 4'b0001; d_dat[0] = 32'h300 + k;
      step();
      if (k == 3) begin
        #1;
        check_eq("full_in_ready0", 64'(in_ready[0]), 64'd0);
      end
    end
    d_vld = '0;
    rr = NA - 1;
    for (int k = 0; k < 5; k++) begin
      rr_pick(!m_ov || d_ordy, d_gnt);
      step();
      if (k < 4) begin
        #1;
        check_eq("drain_data", 64'(out_data), 64'(32'h300 + k));
      end
    end

    // Output backpressure for 3 cycles, then release.
    do_reset();
    d_vld = 4'b0010; d_dat[1] = 32'hB0B0_0000; step();
    d_dat[1] = 32'hB0B0_0001; step();
    d_vld = '0;
    rr_pick(1'b1, d_gnt); step();
    d_ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rr_pick(!m_ov || d_ordy, d_gnt);
      step();
    end
    d_ordy = 1'b1;
    rr_pick(1'b1, d_gnt); step();
    d_gnt = '0; step(); step();

    // Round-robin drain of two flits per agent.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      d_vld = '1;
      for (int i = 0; i < NA; i++) d_dat[i] = 32'hC000_0000 + 32'(i * 16 + k);
      step();
    end
    d_vld = '0;
    rr = NA - 1;
    for (int k = 0; k < 2 * NA; k++) begin
      rr_pick(1'b1, d_gnt);
      step();
      #1;
      check_eq("rr_src",   64'(out_src),   64'(k % NA));
      check_eq("rr_valid", 64'(out_valid), 64'd1);
    end
    d_gnt = '0; step();

    // Illegal grants: multi-hot, then grant to an empty agent; flag is sticky.
    do_reset();
    d_vld = 4'b0010; d_dat[1] = 32'hD00D_0001; step();
    d_vld = '0; d_gnt = 4'b0011; step();
    d_gnt = '0; step(); step();
    d_gnt = 4'b1000; step();
    d_gnt = '0; step();
    #1;
    check_eq("err_sticky", 64'(err_grant), 64'd1);
    check_eq("err_no_pop", 64'(out_valid), 64'd0);

    // Long randomized run with occasional resets.
    do_reset();
    random_cycles(3000, 400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
